and_event_monitor: RTL and testbench

- Downstream consumer of the single-bit AND result produced by the two-input gate sub-block.
- Synchronises and debounces that result, then counts its qualified rising edges in a saturating counter.
- Reports count snapshots to a register/test harness over a valid/ready handshake.
- Also serves as a sequential elaboration target for the SV flow, including a generate-block parameter that must stay local.

---
 rtl/and_event_monitor.sv | 162 ++++++++++++++++
 tb/tb_and_event_monitor.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/and_event_monitor.sv
// and_event_monitor
//
// Consumes the single-bit AND result from the upstream two-input gate, which
// is asynchronous to clk. The signal is synchronised, debounced, and its
// qualified rising edges are counted in a saturating counter. A consumer
// asks for a snapshot with snap_req and receives the captured count over a
// valid/ready handshake.
//
// Parameters:
//   CNT_W         event counter / snapshot width (2..32)
//   STABLE_CYCLES cycles the synchronised input must disagree with the
//                 filtered level before the filtered level follows (1..15)
//   CLR_ON_READ   1: counter and saturation flag restart when a snapshot is
//                 captured; 0: counter free-runs
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_o       raw AND result, asynchronous to clk
//   snap_req   single-cycle request to capture a snapshot
//   cnt_valid  snapshot available (high while reporting)
//   cnt_ready  consumer accepts the snapshot
//   cnt_data   captured event count
//   cnt_sat    counter had saturated when the snapshot was taken
//   busy       high while a snapshot is being reported
module and_event_monitor #(
  parameter int CNT_W         = 8,
  parameter int STABLE_CYCLES = 3,
  parameter int CLR_ON_READ   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_o,
  input  logic             snap_req,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_sat,
  output logic             busy
);

  localparam logic [3:0]       STAB_LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam bit               CLEAR     = (CLR_ON_READ != 0);

  typedef enum logic {
    IDLE,
    REPORT
  } state_t;

  logic             sync_q;
  logic             filt_q;
  logic [3:0]       stab_cnt;
  logic             rise;
  logic [CNT_W-1:0] count;
  logic             sat_q;
  state_t           state_q;
  state_t           state_d;
  logic             capture;

  // Synchroniser. The stage count lives inside the generate block so it is
  // local to it and cannot be overridden from an instantiation.
  if (1) begin : g_sync
    localparam int SYNC_STAGES = 2;
    logic [SYNC_STAGES-1:0] sync_chain;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_chain <= '0;
      end else begin
        sync_chain <= {sync_chain[SYNC_STAGES-2:0], in_o};
      end
    end

    assign sync_q = sync_chain[SYNC_STAGES-1];
  end

  // Debounce filter: filt_q only follows sync_q after it has disagreed for
  // STABLE_CYCLES consecutive samples; any agreement restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= 1'b0;
      stab_cnt <= '0;
    end else if (sync_q == filt_q) begin
      stab_cnt <= '0;
    end else if (stab_cnt == STAB_LAST) begin
      filt_q   <= sync_q;
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt + 4'd1;
    end
  end

  // High in the cycle whose closing edge moves filt_q from 0 to 1, so the
  // counter and the snapshot logic see the edge at the same clock.
  assign rise = sync_q & ~filt_q & (stab_cnt == STAB_LAST);

  // Saturating event counter. With clear-on-read, an edge coinciding with
  // the capture belongs to the new period, so the counter restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sat_q <= 1'b0;
    end else if (capture && CLEAR) begin
      count <= rise ? CNT_W'(1) : '0;
      sat_q <= 1'b0;
    end else if (rise) begin
      if (count == CNT_MAX) begin
        sat_q <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Handshake FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Requests are only taken in IDLE; while reporting they
  // are dropped rather than queued.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          capture = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (cnt_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot registers hold steady for the whole report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_data <= '0;
      cnt_sat  <= 1'b0;
    end else if (capture) begin
      cnt_data <= count;
      cnt_sat  <= sat_q;
    end
  end

  // Valid is derived from the state register so an asynchronous reset drops
  // it immediately.
  assign cnt_valid = (state_q == REPORT);
  assign busy      = (state_q == REPORT);

endmodule

// File: tb/tb_and_event_monitor.sv
// tb_and_event_monitor
//
// Three instances share the same stimulus: defaults, a 4-bit counter and a
// free-running (no clear on read) variant. Expected snapshots are queued
// when a request is driven and compared once the DUT presents them.
module tb_and_event_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_o = 1'b0;
  logic snap_req = 1'b0;
  logic cnt_ready = 1'b0;

  logic       v0, s0, b0;
  logic [7:0] d0;
  logic       v1, s1, b1;
  logic [3:0] d1;
  logic       v2, s2, b2;
  logic [7:0] d2;

  always #5 clk = ~clk;

  and_event_monitor dut (
    .clk(clk), .rst_n(rst_n), .in_o(in_o), .snap_req(snap_req),
    .cnt_valid(v0), .cnt_ready(cnt_ready), .cnt_data(d0), .cnt_sat(s0), .busy(b0)
  );

  and_event_monitor #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_o(in_o), .snap_req(snap_req),
    .cnt_valid(v1), .cnt_ready(cnt_ready), .cnt_data(d1), .cnt_sat(s1), .busy(b1)
  );

  and_event_monitor #(.CLR_ON_READ(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_o(in_o), .snap_req(snap_req),
    .cnt_valid(v2), .cnt_ready(cnt_ready), .cnt_data(d2), .cnt_sat(s2), .busy(b2)
  );

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic        sat;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [33:0] observed(input int inst);
    case (inst)
      0:       observed = {v0, s0, 32'(d0)};
      1:       observed = {v1, s1, 32'(d1)};
      default: observed = {v2, s2, 32'(d2)};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_o = 1'b0;
    snap_req = 1'b0;
    cnt_ready = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse(input int high_cycles, input int low_cycles);
    in_o = 1'b1;
    repeat (high_cycles) tick();
    in_o = 1'b0;
    repeat (low_cycles) tick();
  endtask

  task automatic push_exp(input int inst, input logic [31:0] data, input logic sat, input string name);
    exp_t e;
    e.inst = inst;
    e.data = data;
    e.sat = sat;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic snap_pulse();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  task automatic release_ready();
    cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_o = 1'b0;
    snap_req = 1'b0;
    cnt_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({v0, s0, d0, b0} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got valid=%b sat=%b data=%0d busy=%b, expected all 0", v0, s0, d0, b0);
    end
    checks++;
    if ({v1, b1, v2, b2} !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_variants: got %b, expected 0000", {v1, b1, v2, b2});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({v0, b0} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_release_idle: got valid=%b busy=%b, expected 0 0", v0, b0);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    logic [33:0] got;
    apply_reset();
    repeat (5) pulse(8, 8);
    push_exp(0, 5, 1'b0, "basic_count");
    snap_pulse();
    checks++;
    if (b0 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_busy: got %b, expected 1", b0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = observed(e.inst);
      checks++;
      if (got !== {1'b1, e.sat, e.data}) begin
        failures++;
        $display("[TB] FAIL %s: got valid=%b sat=%b data=%0d, expected valid=1 sat=%b data=%0d", e.name, got[33], got[32], got[31:0], e.sat, e.data);
      end
    end
    release_ready();
    checks++;
    if ({v0, b0} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL basic_valid_one_cycle: got valid=%b busy=%b, expected 0 0", v0, b0);
    end
    push_exp(0, 0, 1'b0, "basic_second_snapshot");
    snap_pulse();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = observed(e.inst);
      checks++;
      if (got !== {1'b1, e.sat, e.data}) begin
        failures++;
        $display("[TB] FAIL %s: got valid=%b sat=%b data=%0d, expected valid=1 sat=%b data=%0d", e.name, got[33], got[32], got[31:0], e.sat, e.data);
      end
    end
    release_ready();
  endtask

  task automatic test_glitch();
    exp_t e;
    logic [33:0] got;
    apply_reset();
    pulse(1, 8);
    pulse(2, 8);
    in_o = 1'b1;
    repeat (3) tick();
    in_o = 1'b0;
    tick();
    checks++;
    if (dut.filt_q !== 1'b0) begin
      failures++;
      $display("[TB] FAIL glitch_filt_early: got %b at edge k+3, expected 0", dut.filt_q);
    end
    tick();
    checks++;
    if (dut.filt_q !== 1'b1) begin
      failures++;
      $display("[TB] FAIL glitch_filt_edge: got %b at edge k+4, expected 1", dut.filt_q);
    end
    repeat (8) tick();
    push_exp(0, 1, 1'b0, "glitch_count");
    snap_pulse();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = observed(e.inst);
      checks++;
      if (got !== {1'b1, e.sat, e.data}) begin
        failures++;
        $display("[TB] FAIL %s: got valid=%b sat=%b data=%0d, expected valid=1 sat=%b data=%0d", e.name, got[33], got[32], got[31:0], e.sat, e.data);
      end
    end
    release_ready();
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [33:0] got;
    apply_reset();
    repeat (20) pulse(8, 8);
    push_exp(1, 15, 1'b1, "sat_capture");
    push_exp(0, 20, 1'b0, "sat_wide_counter");
    snap_pulse();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = observed(e.inst);
      checks++;
      if (got !== {1'b1, e.sat, e.data}) begin
        failures++;
        $display("[TB] FAIL %s: got valid=%b sat=%b data=%0d, expected valid=1 sat=%b data=%0d", e.name, got[33], got[32], got[31:0], e.sat, e.data);
      end
    end
    release_ready();
    repeat (2) pulse(8, 8);
    push_exp(1, 2, 1'b0, "sat_after_clear");
    snap_pulse();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = observed(e.inst);
      checks++;
      if (got !== {1'b1, e.sat, e.data}) begin
        failures++;
        $display("[TB] FAIL %s: got valid=%b sat=%b data=%0d, expected valid=1 sat=%b data=%0d", e.name, got[33], got[32], got[31:0], e.sat, e.data);
      end
    end
    release_ready();
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [33:0] got;
    int hold_errors;
    int extra_valid;
    apply_reset();
    repeat (2) pulse(8, 8);
    push_exp(0, 2, 1'b0, "bp_capture");
    snap_pulse();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = observed(e.inst);
      checks++;
      if (got !== {1'b1, e.sat, e.data}) begin
        failures++;
        $display("[TB] FAIL %s: got valid=%b sat=%b data=%0d, expected valid=1 sat=%b data=%0d", e.name, got[33], got[32], got[31:0], e.sat, e.data);
      end
    end
    hold_errors = 0;
    for (int c = 0; c < 32; c++) begin
      in_o = (c < 24) && ((c % 8) < 4);
      snap_req = (c == 10);
      tick();
      if ({v0, d0} !== {1'b1, 8'd2}) hold_errors++;
    end
    snap_req = 1'b0;
    in_o = 1'b0;
    checks++;
    if (hold_errors != 0) begin
      failures++;
      $display("[TB] FAIL bp_hold_stable: got %0d cycles with valid/data changed, expected 0 (data=%0d valid=%b)", hold_errors, d0, v0);
    end
    release_ready();
    extra_valid = 0;
    repeat (4) begin
      if (v0 !== 1'b0) extra_valid++;
      tick();
    end
    checks++;
    if (extra_valid != 0) begin
      failures++;
      $display("[TB] FAIL bp_no_extra_snapshot: got valid high %0d cycles, expected 0", extra_valid);
    end
    push_exp(0, 3, 1'b0, "bp_next_snapshot");
    snap_pulse();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = observed(e.inst);
      checks++;
      if (got !== {1'b1, e.sat, e.data}) begin
        failures++;
        $display("[TB] FAIL %s: got valid=%b sat=%b data=%0d, expected valid=1 sat=%b data=%0d", e.name, got[33], got[32], got[31:0], e.sat, e.data);
      end
    end
    release_ready();
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic [33:0] got;
    apply_reset();
    repeat (7) pulse(8, 8);
    in_o = 1'b1;
    repeat (4) tick();
    push_exp(0, 7, 1'b0, "sim_clr_capture");
    push_exp(2, 7, 1'b0, "sim_noclr_capture");
    snap_pulse();
    checks++;
    if (dut.filt_q !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sim_edge_aligned: got filt_q=%b on capture edge, expected 1", dut.filt_q);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = observed(e.inst);
      checks++;
      if (got !== {1'b1, e.sat, e.data}) begin
        failures++;
        $display("[TB] FAIL %s: got valid=%b sat=%b data=%0d, expected valid=1 sat=%b data=%0d", e.name, got[33], got[32], got[31:0], e.sat, e.data);
      end
    end
    release_ready();
    repeat (2) tick();
    in_o = 1'b0;
    repeat (8) tick();
    push_exp(0, 1, 1'b0, "sim_clr_new_period");
    push_exp(2, 8, 1'b0, "sim_noclr_running");
    snap_pulse();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = observed(e.inst);
      checks++;
      if (got !== {1'b1, e.sat, e.data}) begin
        failures++;
        $display("[TB] FAIL %s: got valid=%b sat=%b data=%0d, expected valid=1 sat=%b data=%0d", e.name, got[33], got[32], got[31:0], e.sat, e.data);
      end
    end
    release_ready();
  endtask

  task automatic test_async_reset();
    apply_reset();
    pulse(8, 8);
    snap_pulse();
    checks++;
    if ({v0, d0} !== {1'b1, 8'd1}) begin
      failures++;
      $display("[TB] FAIL ar_report_before: got valid=%b data=%0d, expected 1 1", v0, d0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (v0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ar_valid_drop: got %b before next edge, expected 0", v0);
    end
    checks++;
    if ({s0, d0, b0} !== 10'd0) begin
      failures++;
      $display("[TB] FAIL ar_outputs_clear: got sat=%b data=%0d busy=%b, expected all 0", s0, d0, b0);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting and_event_monitor bench");
    test_reset();
    test_basic();
    test_glitch();
    test_saturation();
    test_backpressure();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
